apple2_disk_track_nibblizer: RTL

Encoder feeding the Disk II track buffer. It converts one 4096-byte DOS 3.3 sector-order track image (16 × 256 bytes) into the 6656-byte GCR nibble stream that the Disk II controller replays. Output goes through the controller's ram_write_addr/ram_di/ram_we write port. It sits between the disk-image loader (source memory) and the Disk II block, and re-encodes a track on every head-track change.

---
 rtl/apple2_disk_track_nibblizer.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/apple2_disk_track_nibblizer.sv
// Disk II track encoder: turns one 16x256-byte DOS 3.3 track image into the
// GCR nibble stream for the controller's track buffer, one nibble per 4-cycle slot.
module apple2_disk_track_nibblizer #(
    parameter logic [7:0] VOLUME    = 8'd254,
    parameter int         GAP1      = 48,
    parameter int         GAP2      = 6,
    parameter int         GAP3      = 27,
    parameter int         TRACK_LEN = 6656
) (
    input  logic        clk_14m,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  track_num,
    output logic [11:0] src_addr,
    input  logic [7:0]  src_data,
    output logic [13:0] ram_write_addr,
    output logic [7:0]  ram_di,
    output logic        ram_we,
    output logic        busy,
    output logic        done
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,  S_GAP1      = 4'd1,  S_ADDR_PRO  = 4'd2,
        S_ADDR_BODY = 4'd3,  S_ADDR_EPI  = 4'd4,  S_GAP2      = 4'd5,
        S_DATA_PRO  = 4'd6,  S_DATA_AUX  = 4'd7,  S_DATA_MAIN = 4'd8,
        S_DATA_CSUM = 4'd9,  S_DATA_EPI  = 4'd10, S_GAP3      = 4'd11,
        S_PAD       = 4'd12, S_DONE      = 4'd13
    } state_t;

    localparam logic [13:0] LAST_WR = 14'(TRACK_LEN - 1);

    localparam logic [0:63][7:0] XLATE_TBL = {
        8'h96, 8'h97, 8'h9A, 8'h9B, 8'h9D, 8'h9E, 8'h9F, 8'hA6,
        8'hA7, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB2, 8'hB3,
        8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB9, 8'hBA, 8'hBB, 8'hBC,
        8'hBD, 8'hBE, 8'hBF, 8'hCB, 8'hCD, 8'hCE, 8'hCF, 8'hD3,
        8'hD6, 8'hD7, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE,
        8'hDF, 8'hE5, 8'hE6, 8'hE7, 8'hE9, 8'hEA, 8'hEB, 8'hEC,
        8'hED, 8'hEE, 8'hEF, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6,
        8'hF7, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF
    };

    // Physical-to-logical sector interleave
    localparam logic [0:15][3:0] SKEW = {
        4'd0, 4'd7, 4'd14, 4'd6, 4'd13, 4'd5, 4'd12, 4'd4,
        4'd11, 4'd3, 4'd10, 4'd2, 4'd9, 4'd1, 4'd8, 4'd15
    };

    function automatic logic [7:0] xlate(input logic [5:0] v);
        xlate = XLATE_TBL[v];
    endfunction

    function automatic logic [7:0] pick3(input logic [1:0] sel, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
        case (sel)
            2'd0:    pick3 = a;
            2'd1:    pick3 = b;
            default: pick3 = c;
        endcase
    endfunction

    function automatic logic [8:0] last_cnt(input state_t s);
        case (s)
            S_GAP1:                                         last_cnt = 9'(GAP1 - 1);
            S_ADDR_PRO, S_ADDR_EPI, S_DATA_PRO, S_DATA_EPI: last_cnt = 9'd2;
            S_ADDR_BODY:                                    last_cnt = 9'd7;
            S_GAP2:                                         last_cnt = 9'(GAP2 - 1);
            S_DATA_AUX:                                     last_cnt = 9'd85;
            S_DATA_MAIN:                                    last_cnt = 9'd255;
            S_GAP3:                                         last_cnt = 9'(GAP3 - 1);
            default:                                        last_cnt = 9'd0;
        endcase
    endfunction

    function automatic state_t next_state(input state_t s, input logic [3:0] sec);
        case (s)
            S_GAP1:      next_state = S_ADDR_PRO;
            S_ADDR_PRO:  next_state = S_ADDR_BODY;
            S_ADDR_BODY: next_state = S_ADDR_EPI;
            S_ADDR_EPI:  next_state = S_GAP2;
            S_GAP2:      next_state = S_DATA_PRO;
            S_DATA_PRO:  next_state = S_DATA_AUX;
            S_DATA_AUX:  next_state = S_DATA_MAIN;
            S_DATA_MAIN: next_state = S_DATA_CSUM;
            S_DATA_CSUM: next_state = S_DATA_EPI;
            S_DATA_EPI:  next_state = S_GAP3;
            S_GAP3:      next_state = (sec == 4'd15) ? S_PAD : S_ADDR_PRO;
            default:     next_state = S_PAD;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  sec_q, sec_d;
    logic [5:0]  trk_q, trk_d;
    logic [7:0]  vol_q, vol_d;
    logic [13:0] wr_cnt_q, wr_cnt_d;
    logic [5:0]  prev_q, prev_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d;
    logic [11:0] src_addr_q, src_addr_d;
    logic [13:0] ram_write_addr_q, ram_write_addr_d;
    logic [7:0]  ram_di_q, ram_di_d;
    logic        ram_we_q, ram_we_d, busy_q, busy_d, done_q, done_d;

    logic [7:0]  field_s, aux_hi_s, nib_s, rd_byte_s, aux_j_s;
    logic [5:0]  val_s;

    // Nibble of the current slot; the third aux byte arrives straight from src_data
    always_comb begin
        case (cnt_q[2:1])
            2'd0:    field_s = vol_q;
            2'd1:    field_s = {2'b00, trk_q};
            2'd2:    field_s = {4'h0, sec_q};
            default: field_s = vol_q ^ {2'b00, trk_q} ^ {4'h0, sec_q};
        endcase
        if (cnt_q < 9'd2) begin
            aux_hi_s = 8'h00;
        end else begin
            aux_hi_s = src_data;
        end
        if (state_q == S_DATA_AUX) begin
            val_s = {aux_hi_s[0], aux_hi_s[1], b1_q[0], b1_q[1], b0_q[0], b0_q[1]};
        end else begin
            val_s = b0_q[7:2];
        end
        case (state_q)
            S_ADDR_PRO:              nib_s = pick3(cnt_q[1:0], 8'hD5, 8'hAA, 8'h96);
            S_ADDR_BODY:             nib_s = cnt_q[0] ? (field_s | 8'hAA)
                                                      : ({1'b0, field_s[7:1]} | 8'hAA);
            S_ADDR_EPI, S_DATA_EPI:  nib_s = pick3(cnt_q[1:0], 8'hDE, 8'hAA, 8'hEB);
            S_DATA_PRO:              nib_s = pick3(cnt_q[1:0], 8'hD5, 8'hAA, 8'hAD);
            S_DATA_AUX, S_DATA_MAIN: nib_s = xlate(val_s ^ prev_q);
            S_DATA_CSUM:             nib_s = xlate(prev_q);
            default:                 nib_s = 8'hFF;
        endcase
    end

    // Slot sequencing, write port and source-address generation
    always_comb begin
        state_d          = state_q;
        ph_d             = ph_q;
        cnt_d            = cnt_q;
        sec_d            = sec_q;
        trk_d            = trk_q;
        vol_d            = vol_q;
        wr_cnt_d         = wr_cnt_q;
        prev_d           = prev_q;
        b0_d             = b0_q;
        b1_d             = b1_q;
        ram_write_addr_d = ram_write_addr_q;
        ram_di_d         = ram_di_q;
        ram_we_d         = 1'b0;
        busy_d           = busy_q;
        done_d           = 1'b0;
        rd_byte_s        = 8'h00;
        aux_j_s          = 8'h00;
        src_addr_d       = 12'h000;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_GAP1;
                    ph_d     = 2'd0;
                    cnt_d    = 9'd0;
                    sec_d    = 4'd0;
                    trk_d    = track_num;
                    vol_d    = VOLUME;
                    wr_cnt_d = 14'd0;
                    prev_d   = 6'd0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd1) begin
                    b0_d = src_data;
                end else if (ph_q == 2'd2) begin
                    b1_d = src_data;
                end else begin
                    b0_d = b0_q;
                end
                if (ph_q == 2'd3) begin
                    ram_we_d         = 1'b1;
                    ram_write_addr_d = wr_cnt_q;
                    ram_di_d         = nib_s;
                    wr_cnt_d         = wr_cnt_q + 14'd1;
                    if (state_q == S_DATA_AUX || state_q == S_DATA_MAIN) begin
                        prev_d = val_s;
                    end else if (state_q == S_DATA_PRO) begin
                        prev_d = 6'd0;
                    end else begin
                        prev_d = prev_q;
                    end
                    // Truncate at the buffer end regardless of where the layout is
                    if (wr_cnt_q == LAST_WR) begin
                        state_d = S_DONE;
                    end else if (cnt_q == last_cnt(state_q)) begin
                        state_d = next_state(state_q, sec_q);
                        cnt_d   = 9'd0;
                        if (state_q == S_GAP3) begin
                            sec_d = sec_q + 4'd1;
                        end else begin
                            sec_d = sec_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end else begin
                    ram_we_d = 1'b0;
                end
            end
        endcase

        aux_j_s = 8'(9'd85 - cnt_d);
        case (state_d)
            S_DATA_AUX: begin
                case (ph_d)
                    2'd0:    rd_byte_s = aux_j_s;
                    2'd1:    rd_byte_s = aux_j_s + 8'd86;
                    default: rd_byte_s = aux_j_s + 8'd172;
                endcase
            end
            S_DATA_MAIN: rd_byte_s = cnt_d[7:0];
            default:     rd_byte_s = 8'h00;
        endcase
        if (state_d == S_IDLE || state_d == S_DONE) begin
            src_addr_d = 12'h000;
        end else begin
            src_addr_d = {SKEW[sec_d], rd_byte_s};
        end
    end

    // State and output registers; reset aborts any track in progress
    always_ff @(posedge clk_14m) begin
        if (reset) begin
            state_q          <= S_IDLE;
            ph_q             <= 2'd0;
            cnt_q            <= 9'd0;
            sec_q            <= 4'd0;
            trk_q            <= 6'd0;
            vol_q            <= 8'd0;
            wr_cnt_q         <= 14'd0;
            prev_q           <= 6'd0;
            b0_q             <= 8'd0;
            b1_q             <= 8'd0;
            src_addr_q       <= 12'd0;
            ram_write_addr_q <= 14'd0;
            ram_di_q         <= 8'd0;
            ram_we_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            ph_q             <= ph_d;
            cnt_q            <= cnt_d;
            sec_q            <= sec_d;
            trk_q            <= trk_d;
            vol_q            <= vol_d;
            wr_cnt_q         <= wr_cnt_d;
            prev_q           <= prev_d;
            b0_q             <= b0_d;
            b1_q             <= b1_d;
            src_addr_q       <= src_addr_d;
            ram_write_addr_q <= ram_write_addr_d;
            ram_di_q         <= ram_di_d;
            ram_we_q         <= ram_we_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign src_addr       = src_addr_q;
    assign ram_write_addr = ram_write_addr_q;
    assign ram_di         = ram_di_q;
    assign ram_we         = ram_we_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule
